// File: rtl/fifo_word_packer_if.sv
// Packer bus: FIFO pop side (valid/enr/data) and wide valid/ready word side.
// PACKER_FLUSH_EN adds the flush request line.
interface fifo_word_packer_if #(
  parameter int IN_W  = 8,
  parameter int LANES = 4
);
  logic                  fifo_valid;
  logic [IN_W-1:0]       fifo_data;
  logic                  fifo_enr;
`ifdef PACKER_FLUSH_EN
  logic                  flush;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [IN_W*LANES-1:0] out_data;
  logic [LANES-1:0]      out_keep;
  logic [15:0]           word_count;

`ifdef PACKER_FLUSH_EN
  modport slave (
    input  fifo_valid, fifo_data, flush, out_ready,
    output fifo_enr, out_valid, out_data, out_keep, word_count
  );
  modport master (
    output fifo_valid, fifo_data, flush, out_ready,
    input  fifo_enr, out_valid, out_data, out_keep, word_count
  );
`else
  modport slave (
    input  fifo_valid, fifo_data, out_ready,
    output fifo_enr, out_valid, out_data, out_keep, word_count
  );
  modport master (
    output fifo_valid, fifo_data, out_ready,
    input  fifo_enr, out_valid, out_data, out_keep, word_count
  );
`endif
endinterface

// File: rtl/fifo_word_packer.sv
// Packs LANES FIFO entries into one word; pops at most every other cycle, holds the word until out_ready.
// Optional partial-word flush enabled by defining PACKER_FLUSH_EN.
module fifo_word_packer #(
  parameter int IN_W  = 8,
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  fifo_word_packer_if.slave   bus
);
  localparam int CNT_W = $clog2(LANES + 1);
  localparam int OUT_W = IN_W * LANES;

  typedef enum logic [1:0] {FILL, SETTLE, HOLD} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] lane_cnt_q;
  logic [OUT_W-1:0] data_q;
  logic [LANES-1:0] keep_q;
  logic             valid_q;
  logic [15:0]      word_count_q;
  logic             flush_pend_q;

  logic             pop;
  logic             flush_req;
  logic             lane_last;
  logic [CNT_W-1:0] lane_nxt;

  function automatic logic [LANES-1:0] lane_mask(input logic [CNT_W-1:0] n);
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(n)) lane_mask[i] = 1'b1;
    end
  endfunction

  // FILL is the only state that pops, and SETTLE always follows a pop,
  // so the FIFO's lagging valid can never cause an over-read.
  assign pop       = (state_q == FILL) && bus.fifo_valid;
  assign lane_nxt  = lane_cnt_q + CNT_W'(1);
  assign lane_last = (lane_nxt == CNT_W'(LANES));

`ifdef PACKER_FLUSH_EN
  logic flush_pend_d;

  assign flush_req = bus.flush | flush_pend_q;

  // A request is consumed by any word leaving FILL/SETTLE; one seen in HOLD waits for the next word.
  always_comb begin
    flush_pend_d = 1'b0;
    if (state_q == HOLD)            flush_pend_d = flush_req;
    else if (pop && !lane_last)     flush_pend_d = flush_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flush_pend_q <= 1'b0;
    else      flush_pend_q <= flush_pend_d;
  end
`else
  assign flush_pend_q = 1'b0;
  assign flush_req    = flush_pend_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      lane_cnt_q   <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      valid_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (pop) begin
            data_q[int'(lane_cnt_q)*IN_W +: IN_W] <= bus.fifo_data;
            lane_cnt_q <= lane_nxt;
            if (lane_last) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
              keep_q  <= '1;
            end else begin
              state_q <= SETTLE;
            end
          end else if (flush_req && (lane_cnt_q != '0)) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            keep_q  <= lane_mask(lane_cnt_q);
          end
        end
        SETTLE: begin
          if (flush_req) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            keep_q  <= lane_mask(lane_cnt_q);
          end else begin
            state_q <= FILL;
          end
        end
        HOLD: begin
          // Clearing data here keeps unused lanes of a later flushed word at zero.
          if (bus.out_ready) begin
            state_q      <= FILL;
            valid_q      <= 1'b0;
            lane_cnt_q   <= '0;
            data_q       <= '0;
            keep_q       <= '0;
            word_count_q <= word_count_q + 16'd1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.fifo_enr   = pop;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.out_keep   = keep_q;
  assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: lagging-valid FIFO model, directed word table and corner sequences.
module tb_fifo_word_packer;
  localparam int IN_W  = 8;
  localparam int LANES = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fifo_word_packer_if #(.IN_W(IN_W), .LANES(LANES)) bus ();
  fifo_word_packer #(.IN_W(IN_W), .LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO model whose registered valid reflects the occupancy of the previous cycle
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       fv_q;
  logic       push_req = 1'b0;
  logic [7:0] push_dat = 8'd0;

  always @(posedge clk) begin
    if (push_req) begin
      mem[wr_ptr] <= push_dat;
      wr_ptr      <= wr_ptr + 8'd1;
    end
    if (bus.fifo_enr) rd_ptr <= rd_ptr + 8'd1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) fv_q <= 1'b0;
    else      fv_q <= (wr_ptr != rd_ptr);
  end

  assign bus.fifo_valid = fv_q;
  assign bus.fifo_data  = mem[rd_ptr];

  int   cyc = 0;
  int   overreads = 0;
  int   bad_enr = 0;
  int   back2back = 0;
  logic last_enr = 1'b0;
  int   pop_cyc [$];

  always @(posedge clk) begin
    if (rst) begin
      if (bus.fifo_enr) begin
        pop_cyc.push_back(cyc);
        if (wr_ptr == rd_ptr) overreads++;
        if (!bus.fifo_valid)  bad_enr++;
        if (last_enr)         back2back++;
      end
      last_enr = bus.fifo_enr;
      cyc++;
    end else begin
      cyc      = 0;
      last_enr = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    push_req = 1'b1;
    push_dat = d;
    @(negedge clk);
    push_req = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int limit);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid_seen"}, bus.out_valid, 1'b1);
  endtask

  task automatic accept(input string name, input logic [15:0] exp_wc);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, "_word_count"}, bus.word_count, exp_wc);
    chk({name, "_valid_drop"}, bus.out_valid, 1'b0);
  endtask

  typedef struct {
    logic [7:0]  d0, d1, d2, d3;
    int          gap;
    int          hold;
    logic [31:0] exp_data;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          base;
    int          n;
    int          vcount;
    logic [31:0] words [$];
    logic [15:0] wexp [3];

    vecs[0] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 0, 0, 32'hEFBEADDE, 16'd3};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 3, 2, 32'hFF00FF00, 16'd4};
    vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 1, 1, 32'h04030201, 16'd5};
    vecs[3] = '{8'h80, 8'h7F, 8'hC3, 8'h3C, 0, 3, 32'h3CC37F80, 16'd6};
    wexp[0] = 16'hFFFF;
    wexp[1] = 16'h0000;
    wexp[2] = 16'h0001;

    bus.out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    bus.flush = 1'b0;
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Preload during reset, then check reset values
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("rst_enr",   bus.fifo_enr,   1'b0);
    chk("rst_valid", bus.out_valid,  1'b0);
    chk("rst_data",  bus.out_data,   32'h0);
    chk("rst_keep",  bus.out_keep,   4'h0);
    chk("rst_wc",    bus.word_count, 16'h0);

    rst = 1'b1;
    pop_cyc.delete();
    wait_valid("w1", 30);
    chk("w1_rise_cycle", cyc, 8);
    chk("w1_pop_count", pop_cyc.size(), 4);
    for (int i = 0; i < pop_cyc.size() && i < 4; i++) chk("w1_pop_cycle", pop_cyc[i], 1 + 2 * i);
    chk("w1_data", bus.out_data, 32'h44332211);
    chk("w1_keep", bus.out_keep, 4'hF);

    // Backpressure: word held, FIFO entries untouched
    push(8'h55); push(8'h66); push(8'h77);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_data",  bus.out_data,  32'h44332211);
      chk("hold_enr",   bus.fifo_enr,  1'b0);
    end
    chk("hold_no_pop", pop_cyc.size(), 4);
    accept("w1", 16'd1);
    push(8'h88);
    wait_valid("w2", 30);
    chk("w2_data", bus.out_data, 32'h88776655);
    chk("w2_keep", bus.out_keep, 4'hF);
    accept("w2", 16'd2);

    for (int v = 0; v < 4; v++) begin
      push(vecs[v].d0); repeat (vecs[v].gap) @(negedge clk);
      push(vecs[v].d1); repeat (vecs[v].gap) @(negedge clk);
      push(vecs[v].d2); repeat (vecs[v].gap) @(negedge clk);
      push(vecs[v].d3);
      wait_valid("vec", 40);
      chk("vec_data", bus.out_data, vecs[v].exp_data);
      chk("vec_keep", bus.out_keep, 4'hF);
      for (int h = 0; h < vecs[v].hold; h++) begin
        @(negedge clk);
        chk("vec_hold_data", bus.out_data, vecs[v].exp_data);
      end
      accept("vec", vecs[v].exp_wc);
    end

    // out_ready held high: one HOLD cycle per word
    bus.out_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      push(8'h10 + 8'(i));
      if (bus.out_valid) begin vcount++; words.push_back(bus.out_data); end
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin vcount++; words.push_back(bus.out_data); end
    end
    bus.out_ready = 1'b0;
    chk("rdy_valid_cycles", vcount, 2);
    if (words.size() > 0) chk("rdy_word0", words[0], 32'h13121110);
    if (words.size() > 1) chk("rdy_word1", words[1], 32'h17161514);
    chk("rdy_wc", bus.word_count, 16'd8);

    // Single entry: one pop, no read on the stale valid
    base = pop_cyc.size();
    push(8'h5A);
    repeat (10) @(negedge clk);
    chk("one_pop_count", pop_cyc.size() - base, 1);
    chk("one_no_valid",  bus.out_valid, 1'b0);
    chk("one_overreads", overreads, 0);
    push(8'h5B); push(8'h5C); push(8'h5D);
    wait_valid("one", 30);
    chk("one_data", bus.out_data, 32'h5D5C5B5A);
    accept("one", 16'd9);

    // Asynchronous reset with two lanes captured
    base = pop_cyc.size();
    push(8'h01); push(8'h02);
    n = 0;
    while (pop_cyc.size() < base + 2 && n < 20) begin @(negedge clk); n++; end
    chk("mid_pops", pop_cyc.size() - base, 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_enr",   bus.fifo_enr,   1'b0);
    chk("mid_rst_valid", bus.out_valid,  1'b0);
    chk("mid_rst_data",  bus.out_data,   32'h0);
    chk("mid_rst_keep",  bus.out_keep,   4'h0);
    chk("mid_rst_wc",    bus.word_count, 16'h0);
    @(negedge clk);
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    rst = 1'b1;
    wait_valid("fresh", 30);
    chk("fresh_data", bus.out_data, 32'hA4A3A2A1);
    chk("fresh_keep", bus.out_keep, 4'hF);
    accept("fresh", 16'd1);

    // Counter wrap: preset near the top, then three more words
    @(negedge clk);
    force dut.word_count_q = 16'hFFFE;
    #1 release dut.word_count_q;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      push(8'hE0); push(8'hE1); push(8'hE2); push(8'hE3);
      wait_valid("wrap", 30);
      chk("wrap_data", bus.out_data, 32'hE3E2E1E0);
      accept("wrap", wexp[k]);
    end

`ifdef PACKER_FLUSH_EN
    base = pop_cyc.size();
    push(8'hAA); push(8'hBB);
    n = 0;
    while (pop_cyc.size() < base + 2 && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    wait_valid("flush", 10);
    chk("flush_data", bus.out_data, 32'h0000BBAA);
    chk("flush_keep", bus.out_keep, 4'h3);
    accept("flush", 16'd2);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    chk("flush_empty_ignored", vcount, 0);
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    wait_valid("post_flush", 30);
    chk("post_flush_data", bus.out_data, 32'hC4C3C2C1);
    chk("post_flush_keep", bus.out_keep, 4'hF);
    accept("post_flush", 16'd3);
`endif

    chk("enr_without_valid", bad_enr,   0);
    chk("back_to_back_pops", back2back, 0);
    chk("fifo_overreads",    overreads, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
